// File: rtl/maxnet_controller.sv
// MAXNET winner-take-all controller sequencing a shared external FP adder and multiplier.
// Optional macro MAXNET_ITER_LIMIT_EN enables the MAX_ITER iteration cap and the timeout output.
module maxnet_controller #(
  parameter int unsigned MAX_ITER = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] eps,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [31:0] a4,
  output logic        finish,
  output logic [31:0] out,
  output logic [1:0]  out_idx,
  output logic        no_winner,
  output logic        timeout,
  output logic [7:0]  iter_count,
  output logic        add_req,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic        add_ack,
  input  logic [31:0] add_res,
  output logic        mul_req,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_ack,
  input  logic [31:0] mul_res
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StCheck, StSum, StDiff, StMul, StAcc, StCommit, StDone
  } state_e;

  state_e      state_q;
  logic [31:0] eps_q, s_q, t_q, m_q, out_q;
  logic [31:0] a_q [4];
  logic [31:0] n_q [4];
  logic [1:0]  idx_q, step_q, out_idx_q;
  logic [7:0]  iter_q;
  logic        finish_q, no_winner_q;
  logic        add_req_q, mul_req_q;
  logic [31:0] add_a_q, add_b_q, mul_a_q, mul_b_q;
  logic [3:0]  nz;
  logic [2:0]  nz_cnt;
  logic [1:0]  one_idx;

  function automatic logic [31:0] relu(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  // Both +0 and -0 count as zero.
  always_comb begin
    nz_cnt  = '0;
    one_idx = '0;
    for (int i = 0; i < 4; i++) begin
      nz[i] = |a_q[i][30:0];
      if (nz[i]) begin
        nz_cnt  = nz_cnt + 3'd1;
        one_idx = 2'(i);
      end
    end
  end

`ifdef MAXNET_ITER_LIMIT_EN
  localparam logic [7:0] IterCap = 8'(MAX_ITER);
  logic       timeout_q;
  logic [1:0] max_idx;

  // Activations are non-negative after ReLU, so magnitude order equals bit order.
  always_comb begin
    max_idx = '0;
    for (int i = 1; i < 4; i++) begin
      if (a_q[i][30:0] > a_q[max_idx][30:0]) max_idx = 2'(i);
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      eps_q       <= '0;
      s_q         <= '0;
      t_q         <= '0;
      m_q         <= '0;
      out_q       <= '0;
      idx_q       <= '0;
      step_q      <= '0;
      out_idx_q   <= '0;
      iter_q      <= '0;
      finish_q    <= 1'b0;
      no_winner_q <= 1'b0;
      add_req_q   <= 1'b0;
      mul_req_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        n_q[i] <= '0;
      end
`ifdef MAXNET_ITER_LIMIT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            eps_q       <= eps;
            a_q[0]      <= a1;
            a_q[1]      <= a2;
            a_q[2]      <= a3;
            a_q[3]      <= a4;
            finish_q    <= 1'b0;
            no_winner_q <= 1'b0;
`ifdef MAXNET_ITER_LIMIT_EN
            timeout_q   <= 1'b0;
`endif
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          for (int i = 0; i < 4; i++) a_q[i] <= relu(a_q[i]);
          iter_q  <= '0;
          state_q <= StCheck;
        end
        StCheck: begin
          if (nz_cnt == 3'd0) begin
            no_winner_q <= 1'b1;
            out_q       <= '0;
            out_idx_q   <= '0;
            finish_q    <= 1'b1;
            state_q     <= StDone;
          end else if (nz_cnt == 3'd1) begin
            out_q     <= a_q[one_idx];
            out_idx_q <= one_idx;
            finish_q  <= 1'b1;
            state_q   <= StDone;
`ifdef MAXNET_ITER_LIMIT_EN
          end else if (iter_q == IterCap) begin
            timeout_q <= 1'b1;
            out_q     <= a_q[max_idx];
            out_idx_q <= max_idx;
            finish_q  <= 1'b1;
            state_q   <= StDone;
`endif
          end else begin
            step_q  <= '0;
            state_q <= StSum;
          end
        end
        StSum: begin
          if (!add_req_q) begin
            add_req_q <= 1'b1;
            add_a_q   <= (step_q == 2'd0) ? a_q[0] : s_q;
            add_b_q   <= a_q[step_q + 2'd1];
          end else if (add_ack) begin
            add_req_q <= 1'b0;
            s_q       <= add_res;
            if (step_q == 2'd2) begin
              step_q  <= '0;
              idx_q   <= '0;
              state_q <= StDiff;
            end else begin
              step_q <= step_q + 2'd1;
            end
          end
        end
        StDiff: begin
          if (!add_req_q) begin
            add_req_q <= 1'b1;
            add_a_q   <= s_q;
            add_b_q   <= {~a_q[idx_q][31], a_q[idx_q][30:0]};
          end else if (add_ack) begin
            add_req_q <= 1'b0;
            t_q       <= add_res;
            state_q   <= StMul;
          end
        end
        StMul: begin
          if (!mul_req_q) begin
            mul_req_q <= 1'b1;
            mul_a_q   <= eps_q;
            mul_b_q   <= t_q;
          end else if (mul_ack) begin
            mul_req_q <= 1'b0;
            m_q       <= mul_res;
            state_q   <= StAcc;
          end
        end
        StAcc: begin
          if (!add_req_q) begin
            add_req_q <= 1'b1;
            add_a_q   <= a_q[idx_q];
            add_b_q   <= m_q;
          end else if (add_ack) begin
            add_req_q    <= 1'b0;
            n_q[idx_q]   <= relu(add_res);
            if (idx_q == 2'd3) begin
              state_q <= StCommit;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= StDiff;
            end
          end
        end
        StCommit: begin
          for (int i = 0; i < 4; i++) a_q[i] <= n_q[i];
          if (iter_q != 8'hFF) iter_q <= iter_q + 8'd1;
          state_q <= StCheck;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign finish     = finish_q;
  assign out        = out_q;
  assign out_idx    = out_idx_q;
  assign no_winner  = no_winner_q;
  assign iter_count = iter_q;
  assign add_req    = add_req_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign mul_req    = mul_req_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Scoreboard bench for maxnet_controller with behavioural FP adder/multiplier (random ack latency).
module tb_maxnet_controller;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] eps, a1, a2, a3, a4;
  logic        finish, no_winner, timeout;
  logic [31:0] out;
  logic [1:0]  out_idx;
  logic [7:0]  iter_count;
  logic        add_req, add_ack, mul_req, mul_ack;
  logic [31:0] add_a, add_b, add_res, mul_a, mul_b, mul_res;

  always #5 clk = ~clk;

  maxnet_controller #(.MAX_ITER(16)) dut (
    .clk(clk), .rst(rst), .start(start), .eps(eps),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .finish(finish), .out(out), .out_idx(out_idx), .no_winner(no_winner),
    .timeout(timeout), .iter_count(iter_count),
    .add_req(add_req), .add_a(add_a), .add_b(add_b), .add_ack(add_ack), .add_res(add_res),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_res(mul_res)
  );

  typedef struct {
    bit          snap;     // 1: compare idle outputs at next negedge; 0: compare on finish rise
    bit          chk_out;
    logic [31:0] out;
    logic [1:0]  idx;
    logic        nw;
    logic        to;
    logic [7:0]  iter;
    int          adds;
    int          muls;
  } exp_t;

  exp_t exp_q[$];
  exp_t snap_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done = 1'b0;
  int   add_cnt = 0;
  int   mul_cnt = 0;

  // Single <-> double conversion; normal numbers only, round to nearest even.
  function automatic real s2r(logic [31:0] s);
    logic [10:0] e;
    if (s[30:0] == 31'd0) return 0.0;
    e = 11'({3'b000, s[30:23]}) + 11'd896;
    return $bitstoreal({s[31], e, s[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2s(real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52];
    m = {2'b01, d[51:29]};
    if (d[28] && ((d[27:0] != 28'd0) || d[29])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 11'd1;
    end
    return {d[63], 8'(e - 11'd896), m[22:0]};
  endfunction

  // Adder model
  initial begin : adder_model
    int lat;
    bit pend;
    logic [31:0] x, y;
    pend = 1'b0; lat = 0; x = '0; y = '0;
    add_ack = 1'b0; add_res = '0;
    forever begin
      @(negedge clk);
      if (add_ack) add_ack = 1'b0;
      else if (pend) begin
        lat--;
        if (lat == 0) begin
          add_res = r2s(s2r(x) + s2r(y));
          add_ack = 1'b1;
          pend = 1'b0;
        end
      end else if (add_req) begin
        pend = 1'b1; lat = $urandom_range(1, 5); x = add_a; y = add_b; add_cnt++;
      end
    end
  end

  // Multiplier model; a pending ack still fires after a reset drops the request.
  initial begin : mul_model
    int lat;
    bit pend;
    logic [31:0] x, y;
    pend = 1'b0; lat = 0; x = '0; y = '0;
    mul_ack = 1'b0; mul_res = '0;
    forever begin
      @(negedge clk);
      if (mul_ack) mul_ack = 1'b0;
      else if (pend) begin
        lat--;
        if (lat == 0) begin
          mul_res = r2s(s2r(x) * s2r(y));
          mul_ack = 1'b1;
          pend = 1'b0;
        end
      end else if (mul_req) begin
        pend = 1'b1; lat = $urandom_range(1, 5); x = mul_a; y = mul_b; mul_cnt++;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the only process that compares.
  initial begin : monitor
    bit   fin_prev;
    exp_t e;
    fin_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (snap_q.size() > 0) begin
        e = snap_q.pop_front();
        chk("snap_out", out, e.out);
        chk("snap_out_idx", 32'(out_idx), 32'(e.idx));
        chk("snap_no_winner", 32'(no_winner), 32'(e.nw));
        chk("snap_timeout", 32'(timeout), 32'(e.to));
        chk("snap_iter_count", 32'(iter_count), 32'(e.iter));
        chk("snap_finish", 32'(finish), 32'd0);
        chk("snap_add_req", 32'(add_req), 32'd0);
        chk("snap_mul_req", 32'(mul_req), 32'd0);
      end
      if (finish && !fin_prev) begin
        chk("finish_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e.chk_out) chk("out", out, e.out);
          chk("out_idx", 32'(out_idx), 32'(e.idx));
          chk("no_winner", 32'(no_winner), 32'(e.nw));
          chk("timeout", 32'(timeout), 32'(e.to));
          chk("iter_count", 32'(iter_count), 32'(e.iter));
          chk("add_count", 32'(add_cnt), 32'(e.adds));
          chk("mul_count", 32'(mul_cnt), 32'(e.muls));
        end
      end
      fin_prev = finish;
      if (done) begin
        chk("runs_unfinished", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  function automatic exp_t mk(logic [31:0] o, logic [1:0] idx, logic nw, logic to,
                              logic [7:0] iter, int adds, int muls, bit chk_out);
    exp_t e;
    e.snap = 1'b0; e.chk_out = chk_out; e.out = o; e.idx = idx; e.nw = nw; e.to = to;
    e.iter = iter; e.adds = adds; e.muls = muls;
    return e;
  endfunction

  task automatic push_zero_snap();
    exp_t e;
    e = mk(32'h0, 2'd0, 1'b0, 1'b0, 8'd0, 0, 0, 1'b1);
    e.snap = 1'b1;
    snap_q.push_back(e);
  endtask

  task automatic launch(logic [31:0] e, logic [31:0] x1, logic [31:0] x2, logic [31:0] x3,
                        logic [31:0] x4, exp_t ex);
    @(negedge clk);
    eps = e; a1 = x1; a2 = x2; a3 = x3; a4 = x4; start = 1'b1;
    ex.adds += add_cnt;
    ex.muls += mul_cnt;
    exp_q.push_back(ex);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish();
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (finish) break;
    end
    repeat (2) @(negedge clk);
  endtask

  localparam logic [31:0] NegHalf = 32'hBF000000;
  localparam logic [31:0] Four    = 32'h40800000;
  localparam logic [31:0] One     = 32'h3F800000;
  localparam logic [31:0] NegBig  = 32'hC2FD6666;
  localparam logic [31:0] Big     = 32'h42FD6666;

  initial begin : stimulus
    exp_t basic;
    basic = mk(32'h40600000, 2'd0, 1'b0, 1'b0, 8'd1, 11, 4, 1'b1);
    rst = 1'b0; start = 1'b0; eps = '0; a1 = '0; a2 = '0; a3 = '0; a4 = '0;
    repeat (3) @(posedge clk);
    #1 push_zero_snap();
    @(negedge clk);
    rst = 1'b1;

    // One productive iteration, winner a1 = 3.5
    launch(NegHalf, Four, One, 32'h0, 32'h0, basic);
    wait_finish();

    // a1 clamped by ReLU leaves a single winner; no FP operations issued
    launch(NegHalf, NegBig, 32'h0, 32'h0, Big, mk(Big, 2'd3, 1'b0, 1'b0, 8'd0, 0, 0, 1'b1));
    wait_finish();

    // All zeros, including negative zero
    launch(NegHalf, 32'h0, 32'h80000000, 32'h0, 32'h80000000,
           mk(32'h0, 2'd0, 1'b1, 1'b0, 8'd0, 0, 0, 1'b1));
    wait_finish();

    // Single positive survivor in the middle
    launch(NegHalf, 32'h80000000, One, 32'hBF800000, 32'h0,
           mk(One, 2'd1, 1'b0, 1'b0, 8'd0, 0, 0, 1'b1));
    wait_finish();

    // Stray start during SUM must not disturb the run
    launch(NegHalf, Four, One, 32'h0, 32'h0, basic);
    for (int i = 0; i < 100 && !add_req; i++) @(negedge clk);
    a1 = One; a2 = Four; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish();

    // Reset while a multiply is outstanding, then a clean rerun
    @(negedge clk);
    eps = NegHalf; a1 = Four; a2 = One; a3 = 32'h0; a4 = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !mul_req; i++) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 push_zero_snap();
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1 push_zero_snap();
    repeat (2) @(negedge clk);
    launch(NegHalf, Four, One, 32'h0, 32'h0, basic);
    wait_finish();

`ifdef MAXNET_ITER_LIMIT_EN
    // Permanent tie between a2 and a4: capped at 16 iterations, lowest index wins
    launch(32'hBE4CCCCD, NegBig, Big, 32'h0, Big,
           mk(32'h0, 2'd1, 1'b0, 1'b1, 8'd16, 176, 64, 1'b0));
    wait_finish();
`endif

    repeat (2) @(negedge clk);
    done = 1'b1;
  end

endmodule
